ppct_mult_pipe: RTL and testbench
=================================

Name: ppct_mult_pipe

Overview:
- Parametrised, pipelined column-truncated approximate unsigned multiplier for the PPCT family.
- Generalises the fixed 8-bit, fixed-theta combinational column-approx multiplier in three ways: operand width is a parameter, truncation depth theta is selectable per transaction at run time, and results pass through a 3-stage registered pipeline with valid/ready backpressure.
- Sits between operand producers and accumulation/datapath consumers in approximate-compute layers.

Parameters:
- WIDTH, 8: operand width in bits; product is 2*WIDTH bits.
- THETA_W, 4: width of the run-time theta input.
- MAX_THETA, WIDTH: theta clamp ceiling; must be <= WIDTH.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x  in  WIDTH  multiplicand, unsigned.
- y  in  WIDTH  multiplier, unsigned.
- theta  in  THETA_W  truncation depth for this beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- z  out  2*WIDTH  approximate product.
- theta_eff  out  THETA_W  clamped theta actually applied to z.

Behaviour:
- Arithmetic:
  - Partial-product bit (i,j) = x[j] & y[i], weight 2^(i+j).
  - Every bit with i+j < theta_eff is dropped; all others are summed exactly.
  - Equivalently, row i < theta_eff uses x with its low (theta_eff-i) bits forced to 0, and rows i >= theta_eff use full x.
  - theta_eff = min(theta, MAX_THETA). theta=0 gives the exact product.
  - No overflow: z is always < 2^(2*WIDTH). z <= exact product.
- Pipeline:
  - S1 registers x, y, theta_eff.
  - S2 generates truncated rows and reduces them to two 2*WIDTH partial sums: rows [0, WIDTH/2) and rows [WIDTH/2, WIDTH).
  - S3 adds the two partial sums into z.
- Latency: exactly 3 cycles from an accepted beat (in_valid & in_ready) to out_valid, when there is no stall.
- Handshake and stall:
  - Global stall: adv = !out_valid | out_ready. in_ready = adv (combinational).
  - On adv, every stage shifts, including bubbles. When !adv, all stage registers hold.
  - out_valid, z and theta_eff stay stable while out_valid & !out_ready.
  - Throughput: 1 beat/cycle with out_ready held high.
- Boundary conditions:
  - Back-to-back beats with different theta are each computed with their own theta_eff; theta travels with the data.
  - in_valid while in_ready=0: beat is not taken; the producer must hold it.
  - Simultaneous S3 output handshake and new input: both occur in the same cycle.
- Reset:
  - rst_n=0 at a clock edge clears all stage valid bits. out_valid=0, z=0, theta_eff=0.
  - in_ready=1 in the first cycle after reset release.
  - A reset mid-operation discards in-flight beats; none are emitted afterwards.
- Odd WIDTH: the lower group is rows [0, WIDTH/2) using integer division.

Optional Feature:
- Macro: PPCT_ERR_EN.
- With the macro defined:
  - Adds output err [2*WIDTH-1:0], equal to exact product minus z, aligned with z (same stage and valid).
  - Adds output err_max [2*WIDTH-1:0], a running maximum of err over output handshakes.
  - Adds input err_clr [1], which zeroes err_max synchronously. If err_clr and a handshake occur in the same cycle, clear wins.
  - Reset zeroes err and err_max.
- Without the macro: these ports and the exact-product logic are absent; z behaviour is identical.

Decomposition:
- Package ppct_pkg holds:
  - function clamp_theta, computing min(theta, MAX_THETA);
  - function trunc_row(x, i, theta), returning the masked row;
  - localparam PIPE_DEPTH = 3.
- One sub-module, ppct_row_reduce: combinational S2 logic summing a contiguous row range with truncation. It is instantiated twice, once for the low row group and once for the high row group.

Test Plan (WIDTH=8):
- x=255, y=255, theta=4 -> z=64976 (exact 65025, err=49 when PPCT_ERR_EN is defined); theta_eff=4; out_valid exactly 3 cycles after acceptance.
- x=15, y=1, theta=4 -> z=0. Same operands with theta=0 -> z=15. Sent back-to-back, the outputs appear in consecutive cycles in order.
- theta=15, x=255, y=255 -> theta_eff=8; z equals the exact product minus all bits with i+j<8.
- Stream of 10 beats; out_ready low for 4 cycles mid-stream -> in_ready low during the stall; z is held stable; no beat is lost or duplicated; order is preserved.
- Assert rst_n=0 with 2 beats in flight -> next cycle out_valid=0, z=0; neither beat ever appears.
- Randomised sweep of x, y and theta against a reference model of the truncation rule -> zero mismatches; z <= x*y always.

Source files
------------

// File: rtl/ppct_pkg.sv
// Shared helpers for the PPCT column-truncated multiplier family:
// theta clamping, per-row truncation masks and pipeline depth.
package ppct_pkg;

  localparam int PIPE_DEPTH = 3;
  // Widest operand the row helper supports; rows are carried at this width.
  localparam int PPCT_MAX_W = 32;

  function automatic int clamp_theta(input int theta, input int max_theta);
    return (theta > max_theta) ? max_theta : theta;
  endfunction

  // Row i keeps only partial-product bits whose column i+j reaches theta,
  // i.e. the low (theta-i) bits of x are cleared when i < theta.
  function automatic logic [PPCT_MAX_W-1:0] trunc_row(
    input logic [PPCT_MAX_W-1:0] x,
    input int                    i,
    input int                    theta
  );
    logic [PPCT_MAX_W-1:0] mask;
    mask = '1;
    if (theta > i) mask = mask << (theta - i);
    return x & mask;
  endfunction

endpackage

// File: rtl/ppct_row_reduce.sv
// Combinational sum of truncated partial-product rows [ROW_LO, ROW_HI),
// each row shifted to its weight 2^i. Used twice in the middle stage.
module ppct_row_reduce
  import ppct_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int THETA_W = 4,
  parameter int ROW_LO  = 0,
  parameter int ROW_HI  = 4
) (
  input  logic [WIDTH-1:0]           x,
  input  logic [ROW_HI-ROW_LO-1:0]   y_rows,
  input  logic [THETA_W-1:0]         theta_eff,
  output logic [2*WIDTH-1:0]         sum
);

  logic [PPCT_MAX_W-1:0] x_ext;
  logic [PPCT_MAX_W-1:0] row;

  always_comb begin
    x_ext            = '0;
    x_ext[WIDTH-1:0] = x;
    row              = '0;
    sum              = '0;
    for (int i = ROW_LO; i < ROW_HI; i++) begin
      row = trunc_row(x_ext, i, int'(theta_eff));
      if (y_rows[i-ROW_LO]) sum = sum + ((2*WIDTH)'(row) << i);
    end
  end

endmodule

// File: rtl/ppct_mult_pipe.sv
// Three-stage pipelined column-truncated unsigned multiplier with run-time theta.
// Define PPCT_ERR_EN to add err / err_max outputs and the err_clr input.
module ppct_mult_pipe
  import ppct_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int THETA_W   = 4,
  parameter int MAX_THETA = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  input  logic [THETA_W-1:0]   theta,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   z,
`ifdef PPCT_ERR_EN
  output logic [2*WIDTH-1:0]   err,
  output logic [2*WIDTH-1:0]   err_max,
  input  logic                 err_clr,
`endif
  output logic [THETA_W-1:0]   theta_eff
);

  localparam int LO_ROWS = WIDTH / 2;
  localparam int PW      = 2 * WIDTH;

  // Handshake: a beat moves on a rising edge only when both valid and ready
  // are high; adv is one global enable, so every stage shifts or holds together.
  logic adv;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_x_q, s1_x_d, s1_y_q, s1_y_d;
  logic [THETA_W-1:0] s1_theta_q, s1_theta_d;

  logic               s2_valid_q, s2_valid_d;
  logic [PW-1:0]      s2_lo_q, s2_lo_d, s2_hi_q, s2_hi_d;
  logic [THETA_W-1:0] s2_theta_q, s2_theta_d;

  logic               s3_valid_q, s3_valid_d;
  logic [PW-1:0]      s3_z_q, s3_z_d;
  logic [THETA_W-1:0] s3_theta_q, s3_theta_d;

  logic [PW-1:0]      lo_sum, hi_sum;

`ifdef PPCT_ERR_EN
  logic [PW-1:0]      s2_exact_q, s2_exact_d;
  logic [PW-1:0]      s3_err_q, s3_err_d;
  logic [PW-1:0]      err_max_q, err_max_d;
`endif

  ppct_row_reduce #(
    .WIDTH(WIDTH), .THETA_W(THETA_W), .ROW_LO(0), .ROW_HI(LO_ROWS)
  ) u_lo (
    .x(s1_x_q), .y_rows(s1_y_q[LO_ROWS-1:0]), .theta_eff(s1_theta_q), .sum(lo_sum)
  );

  ppct_row_reduce #(
    .WIDTH(WIDTH), .THETA_W(THETA_W), .ROW_LO(LO_ROWS), .ROW_HI(WIDTH)
  ) u_hi (
    .x(s1_x_q), .y_rows(s1_y_q[WIDTH-1:LO_ROWS]), .theta_eff(s1_theta_q), .sum(hi_sum)
  );

  always_comb begin
    adv        = !s3_valid_q || out_ready;
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_theta_d = s1_theta_q;
    s2_valid_d = s2_valid_q;
    s2_lo_d    = s2_lo_q;
    s2_hi_d    = s2_hi_q;
    s2_theta_d = s2_theta_q;
    s3_valid_d = s3_valid_q;
    s3_z_d     = s3_z_q;
    s3_theta_d = s3_theta_q;
    if (adv) begin
      s1_valid_d = in_valid;
      s1_x_d     = x;
      s1_y_d     = y;
      s1_theta_d = THETA_W'(clamp_theta(int'(theta), MAX_THETA));
      s2_valid_d = s1_valid_q;
      s2_lo_d    = lo_sum;
      s2_hi_d    = hi_sum;
      s2_theta_d = s1_theta_q;
      s3_valid_d = s2_valid_q;
      s3_z_d     = s2_lo_q + s2_hi_q;
      s3_theta_d = s2_theta_q;
    end
  end

`ifdef PPCT_ERR_EN
  always_comb begin
    s2_exact_d = s2_exact_q;
    s3_err_d   = s3_err_q;
    err_max_d  = err_max_q;
    if (adv) begin
      s2_exact_d = PW'(s1_x_q) * PW'(s1_y_q);
      s3_err_d   = s2_exact_q - (s2_lo_q + s2_hi_q);
    end
    // Clear takes priority over an update from a simultaneous handshake.
    if (err_clr) err_max_d = '0;
    else if (s3_valid_q && out_ready && (s3_err_q > err_max_q)) err_max_d = s3_err_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_exact_q <= '0;
      s3_err_q   <= '0;
      err_max_q  <= '0;
    end else begin
      s2_exact_q <= s2_exact_d;
      s3_err_q   <= s3_err_d;
      err_max_q  <= err_max_d;
    end
  end

  assign err     = s3_err_q;
  assign err_max = err_max_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_theta_q <= '0;
      s2_valid_q <= 1'b0;
      s2_lo_q    <= '0;
      s2_hi_q    <= '0;
      s2_theta_q <= '0;
      s3_valid_q <= 1'b0;
      s3_z_q     <= '0;
      s3_theta_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_theta_q <= s1_theta_d;
      s2_valid_q <= s2_valid_d;
      s2_lo_q    <= s2_lo_d;
      s2_hi_q    <= s2_hi_d;
      s2_theta_q <= s2_theta_d;
      s3_valid_q <= s3_valid_d;
      s3_z_q     <= s3_z_d;
      s3_theta_q <= s3_theta_d;
    end
  end

  assign in_ready  = adv;
  assign out_valid = s3_valid_q;
  assign z         = s3_z_q;
  assign theta_eff = s3_theta_q;

endmodule

// File: tb/tb_ppct_mult_pipe.sv
// Bench for ppct_mult_pipe (WIDTH=8): directed scenarios plus a randomised
// sweep against a bit-level model of the column truncation rule.
module tb_ppct_mult_pipe;
  import ppct_pkg::*;

  localparam int WIDTH     = 8;
  localparam int THETA_W   = 4;
  localparam int MAX_THETA = 8;
  localparam int PW        = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [WIDTH-1:0]   x = '0;
  logic [WIDTH-1:0]   y = '0;
  logic [THETA_W-1:0] theta = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [PW-1:0]      z;
  logic [THETA_W-1:0] theta_eff;
`ifdef PPCT_ERR_EN
  logic [PW-1:0]      err;
  logic [PW-1:0]      err_max;
  logic               err_clr = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  ppct_mult_pipe #(.WIDTH(WIDTH), .THETA_W(THETA_W), .MAX_THETA(MAX_THETA)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .theta(theta), .out_valid(out_valid), .out_ready(out_ready),
    .z(z),
`ifdef PPCT_ERR_EN
    .err(err), .err_max(err_max), .err_clr(err_clr),
`endif
    .theta_eff(theta_eff)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [PW-1:0]      exp_q[$];
  logic [THETA_W-1:0] exp_t_q[$];
  logic [PW-1:0]      exp_p_q[$];
  int                 acc_cyc_q[$];
  logic [PW-1:0]      got_q[$];
  logic [THETA_W-1:0] got_t_q[$];
  int                 got_cyc_q[$];
`ifdef PPCT_ERR_EN
  logic [PW-1:0]      got_e_q[$];
`endif

  logic          last_in_ready;
  logic          last_out_valid;
  logic [PW-1:0] last_z;

  // Sum every partial-product bit whose column reaches the clamped theta.
  function automatic logic [PW-1:0] ref_z(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] t);
    int te;
    int s;
    te = (int'(t) > MAX_THETA) ? MAX_THETA : int'(t);
    s  = 0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        if (b[i] && a[j] && (i + j) >= te) s += (1 << (i + j));
    return s[PW-1:0];
  endfunction

  task automatic clear_queues();
    exp_q.delete(); exp_t_q.delete(); exp_p_q.delete(); acc_cyc_q.delete();
    got_q.delete(); got_t_q.delete(); got_cyc_q.delete();
`ifdef PPCT_ERR_EN
    got_e_q.delete();
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drive one cycle, sample at posedge+2, advance a cycle.
  task automatic step(input logic iv, input logic [7:0] xi, input logic [7:0] yi,
                      input logic [3:0] ti, input logic ordy, output logic taken);
    in_valid  = iv;
    x         = xi;
    y         = yi;
    theta     = ti;
    out_ready = ordy;
    #1;
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    last_z         = z;
    taken = iv && in_ready;
    if (taken) begin
      exp_q.push_back(ref_z(xi, yi, ti));
      exp_t_q.push_back((ti > 4'd8) ? 4'd8 : ti);
      exp_p_q.push_back(16'(xi) * 16'(yi));
      acc_cyc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      got_q.push_back(z);
      got_t_q.push_back(theta_eff);
      got_cyc_q.push_back(cyc);
`ifdef PPCT_ERR_EN
      got_e_q.push_back(err);
`endif
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send_beat(input logic [7:0] xi, input logic [7:0] yi, input logic [3:0] ti);
    logic tk;
    int   guard;
    guard = 0;
    tk    = 1'b0;
    while (!tk && guard < 50) begin
      step(1'b1, xi, yi, ti, 1'b1, tk);
      guard++;
    end
    if (!tk) begin
      n_checks++;
      $display("FAIL send_timeout: beat not accepted after %0d cycles", guard);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    logic tk;
    int   guard;
    guard = 0;
    while (got_q.size() < n && guard < 50) begin
      step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, tk);
      guard++;
    end
    if (got_q.size() < n) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d results, need %0d", got_q.size(), n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (z !== 16'd0) $display("FAIL reset_z: got %0d want 0", z); else n_pass++;
    n_checks++; if (theta_eff !== 4'd0) $display("FAIL reset_theta_eff: got %0d want 0", theta_eff); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
`ifdef PPCT_ERR_EN
    n_checks++; if (err !== 16'd0) $display("FAIL reset_err: got %0d want 0", err); else n_pass++;
    n_checks++; if (err_max !== 16'd0) $display("FAIL reset_err_max: got %0d want 0", err_max); else n_pass++;
`endif
    @(posedge clk); cyc++; #1;
  endtask

  task automatic test_latency();
    clear_queues();
    send_beat(8'd255, 8'd255, 4'd4);
    drain(1);
    n_checks++; if (got_q.size() !== 1) $display("FAIL lat_count: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++; if (got_q[0] !== 16'd64976) $display("FAIL lat_z: got %0d want 64976", got_q[0]); else n_pass++;
      n_checks++; if (got_t_q[0] !== 4'd4) $display("FAIL lat_theta_eff: got %0d want 4", got_t_q[0]); else n_pass++;
      n_checks++;
      if (got_cyc_q[0] - acc_cyc_q[0] !== PIPE_DEPTH)
        $display("FAIL lat_cycles: got %0d want %0d", got_cyc_q[0] - acc_cyc_q[0], PIPE_DEPTH);
      else n_pass++;
`ifdef PPCT_ERR_EN
      n_checks++; if (got_e_q[0] !== 16'd49) $display("FAIL lat_err: got %0d want 49", got_e_q[0]); else n_pass++;
      n_checks++; if (err_max !== 16'd49) $display("FAIL lat_err_max: got %0d want 49", err_max); else n_pass++;
`endif
    end
  endtask

  task automatic test_theta_pair();
    clear_queues();
    send_beat(8'd15, 8'd1, 4'd4);
    send_beat(8'd15, 8'd1, 4'd0);
    drain(2);
    n_checks++; if (got_q.size() !== 2) $display("FAIL pair_count: got %0d want 2", got_q.size()); else n_pass++;
    if (got_q.size() == 2) begin
      n_checks++; if (got_q[0] !== 16'd0) $display("FAIL pair_z0: got %0d want 0", got_q[0]); else n_pass++;
      n_checks++; if (got_q[1] !== 16'd15) $display("FAIL pair_z1: got %0d want 15", got_q[1]); else n_pass++;
      n_checks++; if (got_t_q[1] !== 4'd0) $display("FAIL pair_theta1: got %0d want 0", got_t_q[1]); else n_pass++;
      n_checks++;
      if (got_cyc_q[1] !== got_cyc_q[0] + 1)
        $display("FAIL pair_consecutive: got cycles %0d,%0d want adjacent", got_cyc_q[0], got_cyc_q[1]);
      else n_pass++;
    end
  endtask

  task automatic test_clamp();
    clear_queues();
    send_beat(8'd255, 8'd255, 4'd15);
    drain(1);
    n_checks++; if (got_q.size() !== 1) $display("FAIL clamp_count: got %0d want 1", got_q.size()); else n_pass++;
    if (got_q.size() > 0) begin
      n_checks++; if (got_t_q[0] !== 4'd8) $display("FAIL clamp_theta_eff: got %0d want 8", got_t_q[0]); else n_pass++;
      n_checks++; if (got_q[0] !== 16'd63232) $display("FAIL clamp_z: got %0d want 63232", got_q[0]); else n_pass++;
    end
  endtask

  task automatic test_stall();
    logic [7:0]    bx[10];
    logic [7:0]    by[10];
    logic [3:0]    bt[10];
    logic [PW-1:0] held;
    logic          tk;
    logic          ordy;
    int            k;
    int            lc;
    clear_queues();
    for (int i = 0; i < 10; i++) begin
      bx[i] = 8'($urandom_range(0, 255));
      by[i] = 8'($urandom_range(0, 255));
      bt[i] = 4'($urandom_range(0, 15));
    end
    k = 0; lc = 0; held = '0;
    while ((k < 10 || got_q.size() < 10) && lc < 100) begin
      ordy = !(lc >= 4 && lc < 8);
      step(k < 10, bx[k < 10 ? k : 0], by[k < 10 ? k : 0], bt[k < 10 ? k : 0], ordy, tk);
      if (lc == 4) held = last_z;
      if (lc >= 4 && lc < 8) begin
        n_checks++; if (last_in_ready !== 1'b0) $display("FAIL stall_in_ready c%0d: got %0b want 0", lc, last_in_ready); else n_pass++;
        n_checks++; if (last_out_valid !== 1'b1) $display("FAIL stall_out_valid c%0d: got %0b want 1", lc, last_out_valid); else n_pass++;
        n_checks++; if (last_z !== held) $display("FAIL stall_z_hold c%0d: got %0d want %0d", lc, last_z, held); else n_pass++;
      end
      if (tk) k++;
      lc++;
    end
    in_valid = 1'b0;
    n_checks++; if (got_q.size() !== 10) $display("FAIL stall_count: got %0d want 10", got_q.size()); else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL stall_z[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (got_t_q[i] !== exp_t_q[i]) $display("FAIL stall_theta[%0d]: got %0d want %0d", i, got_t_q[i], exp_t_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic tk;
    clear_queues();
    step(1'b1, 8'd200, 8'd100, 4'd2, 1'b1, tk);
    step(1'b1, 8'd77, 8'd99, 4'd0, 1'b1, tk);
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); cyc++; #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %0b want 0", out_valid); else n_pass++;
    n_checks++; if (z !== 16'd0) $display("FAIL midrst_z: got %0d want 0", z); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %0b want 1", in_ready); else n_pass++;
    got_q.delete();
    repeat (8) step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, tk);
    n_checks++; if (got_q.size() !== 0) $display("FAIL midrst_ghost: got %0d results want 0", got_q.size()); else n_pass++;
  endtask

  task automatic test_random();
    logic       tk;
    logic       pend;
    logic [7:0] px;
    logic [7:0] py;
    logic [3:0] pt;
    int         guard;
    clear_queues();
    pend = 1'b0; px = '0; py = '0; pt = '0;
    for (int c = 0; c < 300; c++) begin
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        px   = 8'($urandom_range(0, 255));
        py   = 8'($urandom_range(0, 255));
        pt   = 4'($urandom_range(0, 15));
      end
      step(pend, px, py, pt, $urandom_range(0, 4) != 0, tk);
      if (tk) pend = 1'b0;
    end
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 50) begin
      step(1'b0, 8'd0, 8'd0, 4'd0, 1'b1, tk);
      guard++;
    end
    n_checks++;
    if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rand_z[%0d]: got %0d want %0d", i, got_q[i], exp_q[i]); else n_pass++;
      n_checks++; if (got_t_q[i] !== exp_t_q[i]) $display("FAIL rand_theta[%0d]: got %0d want %0d", i, got_t_q[i], exp_t_q[i]); else n_pass++;
      n_checks++; if (got_q[i] > exp_p_q[i]) $display("FAIL rand_bound[%0d]: got %0d above exact %0d", i, got_q[i], exp_p_q[i]); else n_pass++;
`ifdef PPCT_ERR_EN
      n_checks++;
      if (got_e_q[i] !== exp_p_q[i] - exp_q[i]) $display("FAIL rand_err[%0d]: got %0d want %0d", i, got_e_q[i], exp_p_q[i] - exp_q[i]);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_theta_pair();
    test_clamp();
    test_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
